// File: rtl/sad_best_match.sv
// sad_best_match: tracks the minimum SAD over one full-search window of
// (2*RANGE+1)^2 candidates delivered in raster order. It reports the winning
// SAD and the winner's signed motion vector once per search.
module sad_best_match #(
    parameter int RANGE = 8,
    parameter int MV_W  = 6,
    parameter int SAD_W = 16
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [SAD_W-1:0] sad,
    input  logic             sad_val,
    output logic             busy,
    output logic             done,
    output logic [SAD_W-1:0] best_sad,
    output logic [MV_W-1:0]  best_mv_x,
    output logic [MV_W-1:0]  best_mv_y,
    output logic             stray_err
);

    localparam int W     = 2 * RANGE + 1;
    localparam int NCAND = W * W;
    localparam int CNT_W = $clog2(NCAND);
    localparam int POS_W = $clog2(W);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [POS_W-1:0]   col_q, col_d;
    logic [POS_W-1:0]   row_q, row_d;
    logic [CNT_W-1:0]   cand_cnt_q, cand_cnt_d;
    logic               first_q, first_d;
    logic [SAD_W-1:0]   work_sad_q, work_sad_d;
    logic [POS_W-1:0]   win_col_q, win_col_d;
    logic [POS_W-1:0]   win_row_q, win_row_d;
    logic [SAD_W-1:0]   best_sad_q, best_sad_d;
    logic [MV_W-1:0]    best_mv_x_q, best_mv_x_d;
    logic [MV_W-1:0]    best_mv_y_q, best_mv_y_d;
    logic               stray_err_q, stray_err_d;

    logic               take;
    logic               last_cand;

    // Next-state, candidate compare and result capture.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        cand_cnt_d  = cand_cnt_q;
        first_d     = first_q;
        work_sad_d  = work_sad_q;
        win_col_d   = win_col_q;
        win_row_d   = win_row_q;
        best_sad_d  = best_sad_q;
        best_mv_x_d = best_mv_x_q;
        best_mv_y_d = best_mv_y_q;
        stray_err_d = stray_err_q;

        take      = first_q || (sad < work_sad_q);
        last_cand = (cand_cnt_q == CNT_W'(NCAND - 1));

        case (state_q)
            S_IDLE: begin
                if (sad_val) begin
                    stray_err_d = 1'b1;
                end
                // An accepted start clears the sticky error even if a stray
                // sad_val arrives in the same cycle.
                if (start) begin
                    state_d     = S_SEARCH;
                    col_d       = '0;
                    row_d       = '0;
                    cand_cnt_d  = '0;
                    first_d     = 1'b1;
                    stray_err_d = 1'b0;
                end
            end

            S_SEARCH: begin
                if (sad_val) begin
                    if (take) begin
                        work_sad_d = sad;
                        win_col_d  = col_q;
                        win_row_d  = row_q;
                    end
                    first_d    = 1'b0;
                    cand_cnt_d = cand_cnt_q + CNT_W'(1);
                    if (col_q == POS_W'(W - 1)) begin
                        col_d = '0;
                        row_d = row_q + POS_W'(1);
                    end else begin
                        col_d = col_q + POS_W'(1);
                    end
                    // The result registers load on the same edge as the final
                    // compare so that best_* are already valid while done is
                    // high in the single DONE cycle.
                    if (last_cand) begin
                        state_d     = S_DONE;
                        best_sad_d  = work_sad_d;
                        best_mv_x_d = MV_W'(win_col_d) - MV_W'(RANGE);
                        best_mv_y_d = MV_W'(win_row_d) - MV_W'(RANGE);
                    end
                end
            end

            S_DONE: begin
                if (sad_val) begin
                    stray_err_d = 1'b1;
                end
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            col_q       <= '0;
            row_q       <= '0;
            cand_cnt_q  <= '0;
            first_q     <= 1'b0;
            work_sad_q  <= '0;
            win_col_q   <= '0;
            win_row_q   <= '0;
            best_sad_q  <= '0;
            best_mv_x_q <= '0;
            best_mv_y_q <= '0;
            stray_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            cand_cnt_q  <= cand_cnt_d;
            first_q     <= first_d;
            work_sad_q  <= work_sad_d;
            win_col_q   <= win_col_d;
            win_row_q   <= win_row_d;
            best_sad_q  <= best_sad_d;
            best_mv_x_q <= best_mv_x_d;
            best_mv_y_q <= best_mv_y_d;
            stray_err_q <= stray_err_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign best_sad  = best_sad_q;
    assign best_mv_x = best_mv_x_q;
    assign best_mv_y = best_mv_y_q;
    assign stray_err = stray_err_q;

endmodule

// File: tb/tb_sad_best_match.sv
// Directed testbench for sad_best_match with RANGE=8 (289 candidates).
module tb_sad_best_match;

    localparam int RANGE = 8;
    localparam int MV_W  = 6;
    localparam int SAD_W = 16;
    localparam int N     = 289;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             start = 1'b0;
    logic [SAD_W-1:0] sad = '0;
    logic             sad_val = 1'b0;
    logic             busy;
    logic             done;
    logic [SAD_W-1:0] best_sad;
    logic [MV_W-1:0]  best_mv_x;
    logic [MV_W-1:0]  best_mv_y;
    logic             stray_err;

    int vec  = 0;
    int errs = 0;

    logic [SAD_W-1:0] pat [N];

    sad_best_match #(.RANGE(RANGE), .MV_W(MV_W), .SAD_W(SAD_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .sad(sad), .sad_val(sad_val),
        .busy(busy), .done(done), .best_sad(best_sad), .best_mv_x(best_mv_x),
        .best_mv_y(best_mv_y), .stray_err(stray_err)
    );

    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic fill(input logic [SAD_W-1:0] v);
        for (int i = 0; i < N; i++) pat[i] = v;
    endtask

    // Drive one whole search from pat[]; returns in the cycle after the last
    // sad_val. early counts done pulses seen before the last candidate.
    task automatic drive_search(input int max_gap, input bit stray_with_start,
                                input int restart_at, output int early);
        early   = 0;
        start   = 1'b1;
        sad_val = stray_with_start;
        sad     = '0;
        step();
        start   = 1'b0;
        sad_val = 1'b0;
        for (int i = 0; i < N; i++) begin
            sad     = pat[i];
            sad_val = 1'b1;
            if (i == restart_at) start = 1'b1;
            step();
            start   = 1'b0;
            sad_val = 1'b0;
            if (i < N - 1) begin
                if (done) early++;
                if (max_gap > 0) begin
                    repeat ($urandom_range(0, max_gap)) begin
                        step();
                        if (done) early++;
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (3) step();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b expected 0", busy); end
        vec++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done: got %b expected 0", done); end
        vec++; if (best_sad !== 16'h0000) begin errs++; $display("FAIL reset_best_sad: got %h expected 0000", best_sad); end
        vec++; if (best_mv_x !== 6'd0 || best_mv_y !== 6'd0) begin errs++; $display("FAIL reset_mv: got (%0d,%0d) expected (0,0)", $signed(best_mv_x), $signed(best_mv_y)); end
        vec++; if (stray_err !== 1'b0) begin errs++; $display("FAIL reset_stray: got %b expected 0", stray_err); end
        rstn = 1'b1;
        step();
        vec++; if (busy !== 1'b0) begin errs++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_all_equal();
        int early;
        fill(16'h0100);
        drive_search(0, 1'b0, -1, early);
        vec++; if (early !== 0) begin errs++; $display("FAIL eq_early_done: got %0d expected 0", early); end
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL eq_done: got %b expected 1", done); end
        vec++; if (busy !== 1'b1) begin errs++; $display("FAIL eq_busy_done: got %b expected 1", busy); end
        vec++; if (best_sad !== 16'h0100) begin errs++; $display("FAIL eq_sad: got %h expected 0100", best_sad); end
        vec++; if (best_mv_x !== 6'(-8) || best_mv_y !== 6'(-8)) begin errs++; $display("FAIL eq_mv: got (%0d,%0d) expected (-8,-8)", $signed(best_mv_x), $signed(best_mv_y)); end
        step();
        vec++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL eq_after: got done=%b busy=%b expected 0 0", done, busy); end
    endtask

    task automatic test_single_min();
        int early;
        fill(16'h0200);
        pat[150] = 16'h0010;
        drive_search(0, 1'b0, -1, early);
        vec++; if (early !== 0 || done !== 1'b1) begin errs++; $display("FAIL min150_done: got early=%0d done=%b expected 0 1", early, done); end
        vec++; if (best_sad !== 16'h0010) begin errs++; $display("FAIL min150_sad: got %h expected 0010", best_sad); end
        vec++; if (best_mv_x !== 6'd6 || best_mv_y !== 6'd0) begin errs++; $display("FAIL min150_mv: got (%0d,%0d) expected (6,0)", $signed(best_mv_x), $signed(best_mv_y)); end
        repeat (5) step();
        vec++; if (best_sad !== 16'h0010 || best_mv_x !== 6'd6) begin errs++; $display("FAIL min150_hold: got %h,%0d expected 0010,6", best_sad, $signed(best_mv_x)); end
    endtask

    task automatic test_tie_and_last();
        int early;
        fill(16'h0300);
        pat[20]  = 16'h0005;
        pat[200] = 16'h0005;
        drive_search(0, 1'b0, -1, early);
        vec++; if (early !== 0 || done !== 1'b1) begin errs++; $display("FAIL tie_done: got early=%0d done=%b expected 0 1", early, done); end
        vec++; if (best_sad !== 16'h0005) begin errs++; $display("FAIL tie_sad: got %h expected 0005", best_sad); end
        vec++; if (best_mv_x !== 6'(-5) || best_mv_y !== 6'(-7)) begin errs++; $display("FAIL tie_mv: got (%0d,%0d) expected (-5,-7)", $signed(best_mv_x), $signed(best_mv_y)); end
        step();
        fill(16'h0300);
        pat[288] = 16'h0001;
        drive_search(1, 1'b0, -1, early);
        vec++; if (early !== 0 || done !== 1'b1) begin errs++; $display("FAIL last_done: got early=%0d done=%b expected 0 1", early, done); end
        vec++; if (best_sad !== 16'h0001) begin errs++; $display("FAIL last_sad: got %h expected 0001", best_sad); end
        vec++; if (best_mv_x !== 6'd8 || best_mv_y !== 6'd8) begin errs++; $display("FAIL last_mv: got (%0d,%0d) expected (8,8)", $signed(best_mv_x), $signed(best_mv_y)); end
        step();
    endtask

    task automatic test_extremes();
        int early;
        fill(16'hFFFF);
        drive_search(0, 1'b0, -1, early);
        vec++; if (done !== 1'b1 || best_sad !== 16'hFFFF) begin errs++; $display("FAIL max_sad: got done=%b sad=%h expected 1 ffff", done, best_sad); end
        vec++; if (best_mv_x !== 6'(-8) || best_mv_y !== 6'(-8)) begin errs++; $display("FAIL max_mv: got (%0d,%0d) expected (-8,-8)", $signed(best_mv_x), $signed(best_mv_y)); end
        step();
        for (int i = 0; i < N; i++) pat[i] = 16'(i % 3);
        drive_search(0, 1'b0, -1, early);
        vec++; if (done !== 1'b1 || best_sad !== 16'h0000) begin errs++; $display("FAIL zero_sad: got done=%b sad=%h expected 1 0000", done, best_sad); end
        vec++; if (best_mv_x !== 6'(-8) || best_mv_y !== 6'(-8)) begin errs++; $display("FAIL zero_mv: got (%0d,%0d) expected (-8,-8)", $signed(best_mv_x), $signed(best_mv_y)); end
        step();
    endtask

    task automatic test_stray_restart();
        int early;
        // lone sad_val in IDLE
        sad = 16'h0000; sad_val = 1'b1;
        step();
        sad_val = 1'b0;
        vec++; if (stray_err !== 1'b1) begin errs++; $display("FAIL stray_set: got %b expected 1", stray_err); end
        vec++; if (done !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL stray_nodone: got done=%b busy=%b expected 0 0", done, busy); end
        vec++; if (best_sad !== 16'h0000 || best_mv_x !== 6'(-8)) begin errs++; $display("FAIL stray_hold: got %h,%0d expected 0000,-8", best_sad, $signed(best_mv_x)); end
        step();
        vec++; if (stray_err !== 1'b1) begin errs++; $display("FAIL stray_sticky: got %b expected 1", stray_err); end
        // start with a simultaneous stray sad_val, then a second start mid-search
        fill(16'h0400);
        pat[100] = 16'h0003;
        drive_search(0, 1'b1, 50, early);
        vec++; if (early !== 0) begin errs++; $display("FAIL restart_early: got %0d expected 0", early); end
        vec++; if (done !== 1'b1) begin errs++; $display("FAIL restart_done: got %b expected 1", done); end
        vec++; if (best_sad !== 16'h0003) begin errs++; $display("FAIL restart_sad: got %h expected 0003", best_sad); end
        vec++; if (best_mv_x !== 6'd7 || best_mv_y !== 6'(-3)) begin errs++; $display("FAIL restart_mv: got (%0d,%0d) expected (7,-3)", $signed(best_mv_x), $signed(best_mv_y)); end
        vec++; if (stray_err !== 1'b0) begin errs++; $display("FAIL stray_clear: got %b expected 0", stray_err); end
        step();
    endtask

    task automatic test_reset_mid_search();
        int early;
        int seen;
        logic [SAD_W-1:0] m;
        int idx;
        for (int i = 0; i < N; i++) pat[i] = 16'($urandom_range(1, 4000));
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 100; i++) begin
            sad = pat[i]; sad_val = 1'b1;
            step();
        end
        sad_val = 1'b0;
        rstn = 1'b0;
        #2;
        vec++; if (busy !== 1'b0 || done !== 1'b0) begin errs++; $display("FAIL rst_mid_ctrl: got busy=%b done=%b expected 0 0", busy, done); end
        vec++; if (best_sad !== 16'h0000 || best_mv_x !== 6'd0 || best_mv_y !== 6'd0) begin errs++; $display("FAIL rst_mid_best: got %h,%0d,%0d expected 0000,0,0", best_sad, $signed(best_mv_x), $signed(best_mv_y)); end
        seen = 0;
        repeat (3) begin
            step();
            if (done) seen++;
        end
        rstn = 1'b1;
        repeat (2) begin
            step();
            if (done) seen++;
        end
        vec++; if (seen !== 0) begin errs++; $display("FAIL rst_mid_nodone: got %0d done pulses expected 0", seen); end
        // fresh search with random gaps against a reference minimum search
        m = '0; idx = 0;
        for (int i = 0; i < N; i++) begin
            if (i == 0 || pat[i] < m) begin
                m = pat[i];
                idx = i;
            end
        end
        drive_search(3, 1'b0, -1, early);
        vec++; if (early !== 0 || done !== 1'b1) begin errs++; $display("FAIL rand_done: got early=%0d done=%b expected 0 1", early, done); end
        vec++; if (best_sad !== m) begin errs++; $display("FAIL rand_sad: got %h expected %h", best_sad, m); end
        vec++; if (best_mv_x !== 6'((idx % 17) - RANGE) || best_mv_y !== 6'((idx / 17) - RANGE)) begin
            errs++;
            $display("FAIL rand_mv: got (%0d,%0d) expected (%0d,%0d)", $signed(best_mv_x), $signed(best_mv_y), (idx % 17) - RANGE, (idx / 17) - RANGE);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_all_equal();
        test_single_min();
        test_tie_and_last();
        test_extremes();
        test_stray_restart();
        test_reset_mid_search();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end

endmodule

// File: doc/sad_best_match.md
Name: sad_best_match

Overview:
- Downstream consumer of the 16x16 SAD engine's result stream (sad, sad_val).
- For one full-search window of (2*RANGE+1)^2 candidate positions, evaluated in raster order, it tracks the minimum SAD and converts the winning candidate index into a signed motion vector.
- Produces one result per search. The result is held stable until the next search completes.
- Sits between the SAD engine and the motion-vector writeback logic. The candidate sequencer that drives the SAD engine pulses start before issuing the first cal_en.

Parameters:
- RANGE, 8, search range in pixels; window is W=2*RANGE+1 per axis.
- MV_W, 6, width of each signed MV output. Must hold -RANGE..+RANGE.
- SAD_W, 16, SAD input/output width. Matches the SAD engine output.

Ports:
- clk  input  1  clock
- rstn  input  1  reset
- start  input  1  1-cycle pulse: begin a new search (accepted only in IDLE)
- sad  input  SAD_W  SAD of current candidate, qualified by sad_val
- sad_val  input  1  sad is valid this cycle; one pulse per candidate, raster order
- busy  output  1  high while in SEARCH or DONE
- done  output  1  1-cycle pulse: best_* updated this cycle
- best_sad  output  SAD_W  minimum SAD of last completed search
- best_mv_x  output  MV_W  signed x offset of winner (col - RANGE)
- best_mv_y  output  MV_W  signed y offset of winner (row - RANGE)
- stray_err  output  1  sticky: sad_val seen while not in SEARCH; cleared by accepted start

Behaviour:
- Reset and clock: rstn is an asynchronous, active-low reset; clk is the clock. On reset, all registers and outputs are 0 and the FSM is in IDLE.
- FSM has three states: IDLE, SEARCH, DONE.
- IDLE:
  - start=1 moves to SEARCH next cycle.
  - On that edge: col=0, row=0, cand_cnt=0, first=1, stray_err<=0.
- SEARCH, on each sad_val=1:
  - If first=1 or sad < work_sad (strict unsigned), then work_sad<=sad, win_col<=col, win_row<=row.
  - first<=0 on every accepted sad_val.
  - Equal SAD never replaces the current winner, so the lowest raster index wins ties.
  - Counters: col wraps W-1 -> 0 with row++; cand_cnt++.
- SEARCH exit: when sad_val is accepted with cand_cnt==W*W-1, move to DONE next cycle. The compare/update for that last candidate is applied on the same edge.
- DONE (exactly 1 cycle):
  - done=1.
  - best_sad<=work_sad, best_mv_x<=win_col-RANGE, best_mv_y<=win_row-RANGE (signed, MV_W bits).
  - Next state is IDLE.
- Result timing: best_* change only on the DONE edge and hold through later searches until their DONE. done and the new best_* are visible in the cycle after the last sad_val cycle, i.e. latency is 1 cycle from the final sad_val.
- busy: 1 in SEARCH and DONE, 0 in IDLE.
- start outside IDLE (in SEARCH or DONE) is ignored and does not restart the search.
- sad_val outside SEARCH (in IDLE or DONE) is ignored for the compare and sets stray_err=1.
- start and sad_val in the same IDLE cycle: start is accepted and the sad_val is treated as stray. stray_err ends at 0, because the start clear has priority on that edge.
- There is no gap requirement on sad_val; back-to-back pulses every cycle are supported.
- Reset during SEARCH aborts the search immediately: all outputs return to 0 and no done pulse is generated.
- Widths: the cand_cnt and row/col counters are sized by $clog2 of W*W and W. MV arithmetic is done in MV_W-bit signed.

Test Plan:
- All 289 SADs = 16'h0100 (RANGE=8), back-to-back -> done 1 cycle after the 289th sad_val; best_sad=0x0100, mv=(-8,-8).
- Min 0x0010 at index 150, others 0x0200 -> best_sad=0x0010, mv=(+6,0). Index 150 is row 8, col 14.
- Equal min 0x0005 at indices 20 and 200 -> index 20 wins, mv=(-5,-7); min only at index 288 -> mv=(+8,+8).
- All SADs = 16'hFFFF -> first candidate is still taken: best_sad=0xFFFF, mv=(-8,-8). Separately, sad=0 at index 0 is never displaced.
- sad_val pulse in IDLE -> stray_err=1, no done, best_* unchanged. Next start -> stray_err=0. A second start mid-SEARCH -> ignored; done appears after exactly 289 sad_val.
- rstn low after 100 candidates -> all outputs 0, no done. A fresh search after reset completes correctly; with random gaps between sad_val, the result matches the reference model.
